// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, opcodes and entry types for the reservation station
package reservation_station_pkg;

   localparam int INS_OP_W  = 5;
   localparam int REG_DAT_W = 32;
   localparam int ROB_ADD_W = 4;

   localparam logic [INS_OP_W-1:0] OP_ADD  = 5'd0;
   localparam logic [INS_OP_W-1:0] OP_SUB  = 5'd1;
   localparam logic [INS_OP_W-1:0] OP_AND  = 5'd2;
   localparam logic [INS_OP_W-1:0] OP_OR   = 5'd3;
   localparam logic [INS_OP_W-1:0] OP_XOR  = 5'd4;
   localparam logic [INS_OP_W-1:0] OP_SLL  = 5'd5;
   localparam logic [INS_OP_W-1:0] OP_SRL  = 5'd6;
   localparam logic [INS_OP_W-1:0] OP_SRA  = 5'd7;
   localparam logic [INS_OP_W-1:0] OP_SLT  = 5'd8;
   localparam logic [INS_OP_W-1:0] OP_SLTU = 5'd9;
   localparam logic [INS_OP_W-1:0] OP_BEQ  = 5'd10;
   localparam logic [INS_OP_W-1:0] OP_BNE  = 5'd11;
   localparam logic [INS_OP_W-1:0] OP_JAL  = 5'd12;
   localparam logic [INS_OP_W-1:0] OP_LUI  = 5'd13;

   typedef struct packed {
      logic [INS_OP_W-1:0]  op;
      logic [REG_DAT_W-1:0] pc;
      logic [REG_DAT_W-1:0] imm;
      logic [REG_DAT_W-1:0] v1;
      logic [REG_DAT_W-1:0] v2;
      logic [ROB_ADD_W-1:0] q1;
      logic [ROB_ADD_W-1:0] q2;
      logic                 r1;
      logic                 r2;
      logic [ROB_ADD_W-1:0] qd;
   } rs_entry_t;

   typedef struct packed {
      logic                 r;
      logic [REG_DAT_W-1:0] v;
   } rs_opnd_t;

   // Captures a broadcast for a waiting operand; EX has priority over LSB.
   function automatic rs_opnd_t resolve_opnd(
      input logic                 rdy,
      input logic [REG_DAT_W-1:0] v,
      input logic [ROB_ADD_W-1:0] q,
      input logic                 ex_en,
      input logic [ROB_ADD_W-1:0] ex_qd,
      input logic [REG_DAT_W-1:0] ex_vd,
      input logic                 lsb_en,
      input logic [ROB_ADD_W-1:0] lsb_qd,
      input logic [REG_DAT_W-1:0] lsb_vd
   );
      rs_opnd_t o;
      o.r = rdy;
      o.v = v;
      if (!rdy) begin
         if (ex_en && ex_qd == q) begin
            o.r = 1'b1;
            o.v = ex_vd;
         end else if (lsb_en && lsb_qd == q) begin
            o.r = 1'b1;
            o.v = lsb_vd;
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/reservation_station_prio_enc.sv
// rtl/reservation_station_prio_enc.sv - fixed-priority encoder, index 0 highest
module rs_prio_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - issue/wake-up/select reservation station feeding one execution unit
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE  = 8,
   parameter int RS_IDX_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 iDec_En,
   input  logic [INS_OP_W-1:0]  iDec_Op,
   input  logic [REG_DAT_W-1:0] iDec_Pc,
   input  logic [REG_DAT_W-1:0] iDec_Imm,
   input  logic [REG_DAT_W-1:0] iDec_Vs1,
   input  logic [REG_DAT_W-1:0] iDec_Vs2,
   input  logic [ROB_ADD_W-1:0] iDec_Qs1,
   input  logic [ROB_ADD_W-1:0] iDec_Qs2,
   input  logic                 iDec_Rdy1,
   input  logic                 iDec_Rdy2,
   input  logic [ROB_ADD_W-1:0] iDec_Qd,
   output logic                 oDec_Full,
   input  logic                 iEX_En,
   input  logic [ROB_ADD_W-1:0] iEX_Qd,
   input  logic [REG_DAT_W-1:0] iEX_Vd,
   input  logic                 iLSB_En,
   input  logic [ROB_ADD_W-1:0] iLSB_Qd,
   input  logic [REG_DAT_W-1:0] iLSB_Vd,
   input  logic                 iROB_Clr,
   output logic                 oEX_En,
   output logic [INS_OP_W-1:0]  oEX_Op,
   output logic [REG_DAT_W-1:0] oEX_Pc,
   output logic [REG_DAT_W-1:0] oEX_Imm,
   output logic [REG_DAT_W-1:0] oEX_Vs1,
   output logic [REG_DAT_W-1:0] oEX_Vs2,
   output logic [ROB_ADD_W-1:0] oEX_Qd
);

   logic [RS_SIZE-1:0]  busy;
   logic [RS_SIZE-1:0]  rdy_vec;
   rs_entry_t           ent   [RS_SIZE];
   rs_entry_t           woken [RS_SIZE];
   rs_entry_t           issue_ent;
   rs_opnd_t            wk1, wk2, is1, is2;
   logic [RS_IDX_W-1:0] free_idx, sel_idx;
   logic                free_found, sel_found;
   logic                issue_fire;

   rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
      .req   (~busy),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_sel_enc (
      .req   (rdy_vec),
      .idx   (sel_idx),
      .found (sel_found)
   );

   // Full and ready both look only at pre-edge state, so a dispatch never frees a slot this cycle.
   assign oDec_Full  = ~free_found;
   assign issue_fire = en & iDec_En & free_found & ~iROB_Clr;

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         rdy_vec[i] = busy[i] & ent[i].r1 & ent[i].r2;
      end
   end

   always_comb begin
      wk1 = '0;
      wk2 = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         wk1 = resolve_opnd(ent[i].r1, ent[i].v1, ent[i].q1,
                            iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
         wk2 = resolve_opnd(ent[i].r2, ent[i].v2, ent[i].q2,
                            iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
         woken[i]    = ent[i];
         woken[i].r1 = wk1.r;
         woken[i].v1 = wk1.v;
         woken[i].r2 = wk2.r;
         woken[i].v2 = wk2.v;
      end
   end

   // Issue bypass: a tag broadcast in the issue cycle is captured on the way in.
   always_comb begin
      is1 = resolve_opnd(iDec_Rdy1, iDec_Vs1, iDec_Qs1,
                         iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
      is2 = resolve_opnd(iDec_Rdy2, iDec_Vs2, iDec_Qs2,
                         iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
      issue_ent.op  = iDec_Op;
      issue_ent.pc  = iDec_Pc;
      issue_ent.imm = iDec_Imm;
      issue_ent.v1  = is1.v;
      issue_ent.v2  = is2.v;
      issue_ent.q1  = iDec_Qs1;
      issue_ent.q2  = iDec_Qs2;
      issue_ent.r1  = is1.r;
      issue_ent.r2  = is2.r;
      issue_ent.qd  = iDec_Qd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= '0;
         oEX_En  <= 1'b0;
         oEX_Op  <= '0;
         oEX_Pc  <= '0;
         oEX_Imm <= '0;
         oEX_Vs1 <= '0;
         oEX_Vs2 <= '0;
         oEX_Qd  <= '0;
      end else if (en) begin
         if (iROB_Clr) begin
            busy    <= '0;
            oEX_En  <= 1'b0;
            oEX_Op  <= '0;
            oEX_Pc  <= '0;
            oEX_Imm <= '0;
            oEX_Vs1 <= '0;
            oEX_Vs2 <= '0;
            oEX_Qd  <= '0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy[i]) begin
                  ent[i] <= woken[i];
               end
            end
            if (sel_found) begin
               oEX_En        <= 1'b1;
               oEX_Op        <= ent[sel_idx].op;
               oEX_Pc        <= ent[sel_idx].pc;
               oEX_Imm       <= ent[sel_idx].imm;
               oEX_Vs1       <= ent[sel_idx].v1;
               oEX_Vs2       <= ent[sel_idx].v2;
               oEX_Qd        <= ent[sel_idx].qd;
               busy[sel_idx] <= 1'b0;
            end else begin
               oEX_En  <= 1'b0;
               oEX_Op  <= '0;
               oEX_Pc  <= '0;
               oEX_Imm <= '0;
               oEX_Vs1 <= '0;
               oEX_Vs2 <= '0;
               oEX_Qd  <= '0;
            end
            // Issue targets a non-busy slot, the select a busy one, so they never collide.
            if (issue_fire) begin
               ent[free_idx]  <= issue_ent;
               busy[free_idx] <= 1'b1;
            end
         end
      end
   end

endmodule
